// File: rtl/poly_rej_sampler.sv
// poly_rej_sampler: rejection-samples N coefficients below P from a random word stream, then streams them to the store
// Ports: clk/reset (async, active-high); start pulse begins one polynomial;
// rnd_valid/rnd_in/rnd_ready random word handshake; sink_idle/write_req store request;
// coef_out streamed coefficient; busy/done status; reject_cnt saturating rejections.
module poly_rej_sampler #(
    parameter int P     = 17,
    parameter int N     = 8,
    parameter int LOG_N = 3,
    parameter int B     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         rnd_valid,
    input  logic [B-1:0] rnd_in,
    output logic         rnd_ready,
    input  logic         sink_idle,
    output logic         write_req,
    output logic [B-1:0] coef_out,
    output logic         busy,
    output logic         done,
    output logic [15:0]  reject_cnt
);
    typedef enum logic [1:0] {IDLE, COLLECT, REQ, STREAM} state_t;
    localparam logic [B-1:0]     P_W  = B'(P);
    localparam logic [LOG_N:0]   LAST = (LOG_N + 1)'(N - 1);
    state_t                  state, state_nx;
    logic [LOG_N:0]          count;
    logic [N-1:0][B-1:0]     coefs;
    logic                    accept, last, go;
    assign accept   = state == COLLECT && rnd_valid && rnd_in < P_W;
    assign last     = count == LAST;
    // start coinciding with done is still in IDLE but must not relaunch
    assign go       = start && !done;
    assign busy     = state != IDLE;
    assign coef_out = state == STREAM ? coefs[0] : '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx  = state;
        rnd_ready = 1'b0;
        write_req = 1'b0;
        case (state)
            IDLE:    state_nx = go ? COLLECT : IDLE;
            COLLECT: begin
                rnd_ready = 1'b1;
                state_nx  = accept && last ? REQ : COLLECT;
            end
            REQ: begin
                write_req = sink_idle;
                state_nx  = sink_idle ? STREAM : REQ;
            end
            STREAM:  state_nx = last ? IDLE : STREAM;
            default: state_nx = IDLE;
        endcase
    end
    // coefficients enter at the tail and leave from index 0, so the first accepted word streams first
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            count      <= '0;
            coefs      <= '0;
            reject_cnt <= '0;
            done       <= 1'b0;
        end else begin
            done <= state == STREAM && last;
            case (state)
                IDLE: if (go) begin
                    count      <= '0;
                    reject_cnt <= '0;
                end
                COLLECT: if (accept) begin
                    coefs <= {rnd_in, coefs[N-1:1]};
                    count <= count + 1'b1;
                end else if (rnd_valid && reject_cnt != 16'hFFFF)
                    reject_cnt <= reject_cnt + 1'b1;
                REQ: if (sink_idle) count <= '0;
                STREAM: begin
                    coefs <= {B'(0), coefs[N-1:1]};
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_poly_rej_sampler.sv
// tb_poly_rej_sampler: directed self-checking bench for poly_rej_sampler
module tb_poly_rej_sampler;
    localparam int N = 8;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, rnd_valid = 1'b0, sink_idle = 1'b1;
    logic [4:0]  rnd_in = '0;
    logic        rnd_ready, write_req, busy, done;
    logic [4:0]  coef_out;
    logic [15:0] reject_cnt;
    logic [4:0]  exp_c [N];
    int          n_checks = 0, n_fail = 0;

    poly_rej_sampler dut (
        .clk(clk), .reset(reset), .start(start), .rnd_valid(rnd_valid), .rnd_in(rnd_in),
        .rnd_ready(rnd_ready), .sink_idle(sink_idle), .write_req(write_req), .coef_out(coef_out),
        .busy(busy), .done(done), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_poly();
        @(negedge clk); rnd_valid = 1'b0; start = 1'b1;
        #1 chk("busy_before_start", busy, 0);
        @(negedge clk); start = 1'b0;
        #1 chk("busy_collect", busy, 1);
        chk("reject_cleared", reject_cnt, 0);
        chk("rnd_ready_collect", rnd_ready, 1);
    endtask

    task automatic feed(input logic [4:0] w, input logic st = 1'b0);
        @(negedge clk); rnd_valid = 1'b1; rnd_in = w; start = st;
        #1 chk("rnd_ready_feed", rnd_ready, 1);
    endtask

    task automatic gap();
        @(negedge clk); rnd_valid = 1'b0; rnd_in = 5'd31; start = 1'b0;
        #1 chk("rnd_ready_gap", rnd_ready, 1);
    endtask

    task automatic wait_req();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); rnd_valid = 1'b0; start = 1'b0;
            #1;
            if (write_req) break;
        end
        chk("write_req", write_req, 1);
        chk("rnd_ready_req", rnd_ready, 0);
    endtask

    task automatic check_stream(input logic [15:0] rej, input int st_at);
        for (int i = 0; i < N; i++) begin
            @(negedge clk); start = (i == st_at);
            #1 chk($sformatf("coef%0d", i), coef_out, exp_c[i]);
            chk("write_req_stream", write_req, 0);
            chk("busy_stream", busy, 1);
        end
        @(negedge clk); start = (st_at == N);
        #1 chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("coef_idle", coef_out, 0);
        chk("reject_cnt", reject_cnt, rej);
        @(negedge clk); start = 1'b0;
        #1 chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("reject_hold", reject_cnt, rej);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_rnd_ready", rnd_ready, 0);
        chk("rst_write_req", write_req, 0);
        chk("rst_done", done, 0);
        chk("rst_coef", coef_out, 0);
        chk("rst_reject", reject_cnt, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk); reset = 1'b0;

        // basic sample
        start_poly();
        for (int i = 0; i < N; i++) feed(5'(i));
        wait_req();
        exp_c = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
        check_stream(16'd0, -1);

        // rejection boundary
        start_poly();
        feed(17); feed(16); feed(31); feed(0); feed(17); feed(5);
        feed(9); feed(12); feed(3); feed(1); feed(2);
        wait_req();
        exp_c = '{5'd16, 5'd0, 5'd5, 5'd9, 5'd12, 5'd3, 5'd1, 5'd2};
        check_stream(16'd3, -1);

        // stalls and back-pressure
        sink_idle = 1'b0;
        start_poly();
        feed(4); gap(); feed(8); gap(); feed(15); gap(); feed(16); gap();
        feed(0); gap(); feed(1); gap(); feed(2); gap(); feed(3);
        repeat (10) begin
            @(negedge clk); rnd_valid = 1'b0;
            #1 chk("bp_write_req", write_req, 0);
            chk("bp_rnd_ready", rnd_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(negedge clk); sink_idle = 1'b1;
        #1 chk("bp_write_req_rise", write_req, 1);
        exp_c = '{5'd4, 5'd8, 5'd15, 5'd16, 5'd0, 5'd1, 5'd2, 5'd3};
        check_stream(16'd0, -1);

        // reset during COLLECT after 4 accepts
        start_poly();
        for (int i = 0; i < 4; i++) feed(5'(i));
        @(negedge clk); rnd_valid = 1'b0; reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk); reset = 1'b0;

        // reset during STREAM at coefficient 3
        start_poly();
        feed(9); feed(10); feed(11); feed(12); feed(17); feed(13); feed(14); feed(15); feed(16);
        wait_req();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("pre_reset_coef", coef_out, 5'(9 + i));
        end
        @(negedge clk);
        #1 chk("coef3_before_reset", coef_out, 12);
        reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk); reset = 1'b0;

        // fresh polynomial after reset
        start_poly();
        for (int i = 0; i < N; i++) feed(5'(16 - i));
        wait_req();
        exp_c = '{5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9};
        check_stream(16'd0, -1);

        // start ignored during COLLECT and STREAM
        start_poly();
        feed(1); feed(2, 1'b1);
        for (int i = 3; i <= 8; i++) feed(5'(i));
        wait_req();
        exp_c = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
        check_stream(16'd0, 2);

        // start ignored on the done cycle
        start_poly();
        for (int i = 0; i < N; i++) feed(5'(16 - i));
        wait_req();
        exp_c = '{5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9};
        check_stream(16'd0, N);

        // reject counter saturation
        start_poly();
        repeat (70000) begin
            @(negedge clk); rnd_valid = 1'b1; rnd_in = 5'd31;
        end
        @(negedge clk); rnd_valid = 1'b0;
        #1 chk("sat_reject", reject_cnt, 16'hFFFF);
        chk("sat_still_collect", rnd_ready, 1);
        for (int i = 0; i < N; i++) feed(5'(i));
        wait_req();
        exp_c = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
        check_stream(16'hFFFF, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/poly_rej_sampler.md
Name: poly_rej_sampler

Overview:
- Upstream feeder for the polynomial store stage.
- Consumes a stream of b-bit random words and keeps only those strictly below p (uniform rejection sampling). It collects N accepted coefficients in an internal buffer.
- Once N coefficients are held, it issues a one-cycle write request to the store. It then streams the N coefficients on N consecutive cycles, because the store takes one symbol every cycle once it enters its write state.

Parameters:
- p, 17, ring modulus; accepted coefficients lie in [0, p-1]
- N, 8, coefficients per polynomial
- logN, 3, log2(N); width of the count is logN+1
- b, 5, symbol width, ceil(log2(p))

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins sampling one polynomial; honoured only in IDLE
- rnd_valid  in  1  rnd_in carries a fresh random word this cycle
- rnd_in  in  b  raw random word
- rnd_ready  out  1  sampler consumes rnd_in this cycle (COLLECT only)
- sink_idle  in  1  store is idle and able to accept a write request
- write_req  out  1  drives the store's WRITE and data_in_ready; one-cycle pulse
- coef_out  out  b  coefficient to the store's data_in
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last coefficient has been streamed
- reject_cnt  out  16  number of words rejected for the current polynomial; saturates at 16'hFFFF

Behaviour:
- Reset is asynchronous and active-high and may arrive in any state, mid-operation included. It forces state=IDLE, count=0, buffer=0, reject_cnt=0, and drives rnd_ready, write_req, done and busy to 0 and coef_out to 0. Any partial polynomial is discarded.
- IDLE:
  - start=1 clears count and reject_cnt, then moves to COLLECT.
  - Otherwise the block holds, and reject_cnt keeps the last polynomial's value.
- COLLECT:
  - rnd_ready=1.
  - A word is taken on any cycle with rnd_valid=1.
  - If rnd_in < p (unsigned compare), the word is shifted into the buffer tail and count increments.
  - If rnd_in >= p, the word is dropped and reject_cnt increments (saturating).
  - rnd_in == p is rejected; rnd_in == p-1 and rnd_in == 0 are accepted.
  - When the Nth word is accepted, on that same edge the state moves to REQ and rnd_ready is low from the next cycle. No word beyond the Nth is consumed.
  - rnd_valid=0 leaves count unchanged.
- REQ:
  - write_req=sink_idle, combinational from state, so the request is asserted only when sink_idle=1.
  - On an edge where write_req=1, count is cleared and the state moves to STREAM.
  - While sink_idle=0 the block stays in REQ indefinitely.
- STREAM:
  - coef_out = buffer head, where buffer head is coefficient index count.
  - Cycle H is the request cycle. Cycles H+1 through H+N present coefficients 0 through N-1, exactly one per cycle, with no gaps.
  - The buffer shifts each cycle and count increments.
  - After the cycle presenting coefficient N-1, the state returns to IDLE with done=1 for one cycle.
  - Result: coefficient 0 ends in the store's lowest b-bit slot, and coefficient N-1 in the highest.
- coef_out is 0 outside STREAM.
- start is ignored outside IDLE, including a start on the cycle done is high.
- The state encoding is 2 bits; the unused code goes to IDLE on the next edge.
- Latency from start is N + (number of rejected words) + (rnd_valid stall cycles) + (REQ wait) + N + 1 cycles to done.

Test Plan:
- Basic sample: start, then rnd_in=0,1,...,7 with rnd_valid=1 every cycle, sink_idle=1 → one write_req pulse; coef_out = 0..7 on the following 8 cycles; done; reject_cnt=0; store poly_reg = {7,6,...,0}.
- Rejection boundary: stream 17, 16, 31, 0, 17, 5, 9, 12, 3, 1, 2 → 17, 31 and the second 17 are rejected. Accepted coefficients are 16,0,5,9,12,3,1,2; reject_cnt=3.
- Stalls and back-pressure: rnd_valid toggling 1/0, and sink_idle=0 for 10 cycles after collection → write_req stays low and rnd_ready stays low. When sink_idle rises, write_req pulses, the stream is contiguous and the data is unchanged.
- Reset mid-operation: assert reset during COLLECT after 4 accepts, and again in STREAM at coefficient 3 → every output returns to 0 immediately (asynchronously). A fresh start produces a full, correct polynomial.
- Ignored start: pulse start during COLLECT, during STREAM, and on the done cycle → no restart; the coefficient stream is unchanged; busy drops to 0 after done.
- Saturation: feed 70000 consecutive words equal to 31, then eight valid words → reject_cnt=16'hFFFF; the polynomial completes normally.
